// File: rtl/palette_lut_if.sv
// Pixel, palette-write and status signals for palette_lut.
// The master drives pixels and writes; the slave returns colours and status.
interface palette_lut_if #(
    parameter int unsigned IDX_W = 4,
    parameter int unsigned CH_W  = 4
);
    logic [IDX_W-1:0]  index;
    logic              pix_valid;
    logic              frame_start;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_addr;
    logic [3*CH_W-1:0] wr_data;
    logic              swap_req;
    logic [CH_W-1:0]   red;
    logic [CH_W-1:0]   green;
    logic [CH_W-1:0]   blue;
    logic              out_valid;
    logic              out_transparent;
    logic              busy;
    logic              swap_pending;
    logic              front_bank;

    modport master (
        output index, pix_valid, frame_start, wr_en, wr_addr, wr_data, swap_req,
        input  red, green, blue, out_valid, out_transparent, busy, swap_pending, front_bank
    );

    modport slave (
        input  index, pix_valid, frame_start, wr_en, wr_addr, wr_data, swap_req,
        output red, green, blue, out_valid, out_transparent, busy, swap_pending, front_bank
    );
endinterface

// File: rtl/palette_lut.sv
// Double-buffered colour palette lookup with a 2-cycle pipeline.
// Lookups read the front bank; writes go to the back bank; banks swap at frame_start.
module palette_lut #(
    parameter int unsigned IDX_W     = 4,
    parameter int unsigned CH_W      = 4,  // must not exceed IDX_W
    parameter int unsigned TRANS_IDX = 0
) (
    input logic          Clk,
    input logic          Reset,
    palette_lut_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** IDX_W;
    localparam int unsigned DW    = 3 * CH_W;

    typedef enum logic [1:0] {StInit, StRun, StPend} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] cnt_q;
    logic             front_q;
    logic             swap;
    logic             busy;
    logic [CH_W-1:0]  init_ch;
    logic [DW-1:0]    init_word;

    logic [DW-1:0]    mem [2][DEPTH];

    logic             v1_q;
    logic             t1_q;
    logic [IDX_W-1:0] idx1_q;
    logic             ov_q;
    logic             ot_q;
    logic [DW-1:0]    rgb_q;

    assign busy      = (state_q == StInit);
    assign init_ch   = cnt_q[IDX_W-1 -: CH_W];
    assign init_word = {init_ch, init_ch, init_ch};

    always_comb begin
        state_d = state_q;
        swap    = 1'b0;
        case (state_q)
            StInit: begin
                if (cnt_q == IDX_W'(DEPTH - 1)) state_d = StRun;
            end
            StRun: begin
                // Request and frame start together swap immediately
                if (bus.swap_req) begin
                    if (bus.frame_start) swap = 1'b1;
                    else                 state_d = StPend;
                end
            end
            StPend: begin
                if (bus.frame_start) begin
                    swap    = 1'b1;
                    state_d = StRun;
                end
            end
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StInit;
            cnt_q   <= '0;
            front_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (busy) cnt_q <= cnt_q + 1'b1;
            if (swap) front_q <= ~front_q;
        end
    end

    // Writes use the pre-swap back bank, so a write on the swap edge lands in the new front
    always_ff @(posedge Clk) begin
        if (busy) begin
            mem[0][cnt_q] <= init_word;
            mem[1][cnt_q] <= init_word;
        end else if (bus.wr_en) begin
            mem[~front_q][bus.wr_addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            v1_q   <= 1'b0;
            t1_q   <= 1'b0;
            idx1_q <= '0;
            ov_q   <= 1'b0;
            ot_q   <= 1'b0;
            rgb_q  <= '0;
        end else begin
            v1_q   <= bus.pix_valid & ~busy;
            t1_q   <= (bus.index == IDX_W'(TRANS_IDX));
            idx1_q <= bus.index;
            ov_q   <= v1_q;
            ot_q   <= v1_q & t1_q;
            if (v1_q) rgb_q <= mem[front_q][idx1_q];
        end
    end

    assign bus.red             = rgb_q[DW-1 -: CH_W];
    assign bus.green           = rgb_q[2*CH_W-1 -: CH_W];
    assign bus.blue            = rgb_q[CH_W-1:0];
    assign bus.out_valid       = ov_q;
    assign bus.out_transparent = ot_q;
    assign bus.busy            = busy;
    assign bus.swap_pending    = (state_q == StPend);
    assign bus.front_bank      = front_q;
endmodule

// File: tb/tb_palette_lut.sv
// Directed bench for palette_lut: table-driven lookups plus swap, init and reset sequences.
module tb_palette_lut;
    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    palette_lut_if #(.IDX_W(4), .CH_W(4)) bus ();

    palette_lut #(.IDX_W(4), .CH_W(4), .TRANS_IDX(0)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0] idx;
        int         r;
        int         g;
        int         b;
        int         tr;
    } vec_t;

    vec_t vecs[6];
    int   total = 0;
    int   bad   = 0;
    int   n;
    int   ov_seen;

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_rgb(input string name, input int r, input int g, input int b);
        chk({name, ".red"}, 32'(bus.red), r);
        chk({name, ".green"}, 32'(bus.green), g);
        chk({name, ".blue"}, 32'(bus.blue), b);
    endtask

    task automatic lookup(input logic [3:0] idx);
        bus.index     = idx;
        bus.pix_valid = 1'b1;
        tick();
        bus.pix_valid = 1'b0;
        tick();
    endtask

    // Runs until busy drops, counting cycles and any out_valid seen meanwhile
    task automatic wait_init(output int cycles, output int ovs);
        cycles = 0;
        ovs    = 0;
        while (bus.busy === 1'b1 && cycles < 100) begin
            tick();
            cycles++;
            if (bus.out_valid === 1'b1) ovs++;
        end
    endtask

    initial begin
        vecs[0] = '{idx: 4'd9,  r: 9,  g: 9,  b: 9,  tr: 0};
        vecs[1] = '{idx: 4'd0,  r: 0,  g: 0,  b: 0,  tr: 1};
        vecs[2] = '{idx: 4'd15, r: 15, g: 15, b: 15, tr: 0};
        vecs[3] = '{idx: 4'd1,  r: 1,  g: 1,  b: 1,  tr: 0};
        vecs[4] = '{idx: 4'd0,  r: 0,  g: 0,  b: 0,  tr: 1};
        vecs[5] = '{idx: 4'd12, r: 12, g: 12, b: 12, tr: 0};

        bus.index       = '0;
        bus.pix_valid   = 1'b0;
        bus.frame_start = 1'b0;
        bus.wr_en       = 1'b0;
        bus.wr_addr     = '0;
        bus.wr_data     = '0;
        bus.swap_req    = 1'b0;
        Reset           = 1'b1;
        tick();
        tick();
        chk("rst.busy", 32'(bus.busy), 1);
        chk("rst.front", 32'(bus.front_bank), 0);
        chk("rst.pending", 32'(bus.swap_pending), 0);
        chk("rst.out_valid", 32'(bus.out_valid), 0);
        chk("rst.trans", 32'(bus.out_transparent), 0);
        chk_rgb("rst", 0, 0, 0);

        Reset = 1'b0;
        wait_init(n, ov_seen);
        chk("init.cycles", 32'(n), 16);

        for (int i = 0; i < 6; i++) begin
            lookup(vecs[i].idx);
            chk($sformatf("vec%0d.valid", i), 32'(bus.out_valid), 1);
            chk($sformatf("vec%0d.trans", i), 32'(bus.out_transparent), vecs[i].tr);
            chk_rgb($sformatf("vec%0d", i), vecs[i].r, vecs[i].g, vecs[i].b);
        end
        tick();
        chk("hold.valid", 32'(bus.out_valid), 0);
        chk("hold.trans", 32'(bus.out_transparent), 0);
        chk_rgb("hold", 12, 12, 12);

        // Back-bank write invisible until swap
        bus.wr_en = 1'b1; bus.wr_addr = 4'd3; bus.wr_data = 12'hD95;
        tick();
        bus.wr_en = 1'b0;
        lookup(4'd3);
        chk_rgb("preswap", 3, 3, 3);
        bus.swap_req = 1'b1;
        tick();
        bus.swap_req = 1'b0;
        chk("arm.pending", 32'(bus.swap_pending), 1);
        chk("arm.front", 32'(bus.front_bank), 0);
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        chk("swap.front", 32'(bus.front_bank), 1);
        chk("swap.pending", 32'(bus.swap_pending), 0);
        lookup(4'd3);
        chk_rgb("postswap", 13, 9, 5);

        // Same-cycle request and frame start
        bus.swap_req = 1'b1; bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        chk("same.pending", 32'(bus.swap_pending), 0);
        chk("same.front", 32'(bus.front_bank), 0);
        tick();
        chk("dbl.pending1", 32'(bus.swap_pending), 1);
        tick();
        chk("dbl.pending2", 32'(bus.swap_pending), 1);
        chk("dbl.front", 32'(bus.front_bank), 0);
        bus.swap_req = 1'b0; bus.frame_start = 1'b1;
        tick();
        chk("dbl.swap", 32'(bus.front_bank), 1);
        tick();
        bus.frame_start = 1'b0;
        chk("nofs.front", 32'(bus.front_bank), 1);

        // Write on the swap edge goes to the bank that becomes front
        bus.swap_req = 1'b1;
        tick();
        bus.swap_req = 1'b0; bus.frame_start = 1'b1;
        bus.wr_en = 1'b1; bus.wr_addr = 4'd7; bus.wr_data = 12'h123;
        tick();
        bus.frame_start = 1'b0; bus.wr_en = 1'b0;
        chk("edgewr.front", 32'(bus.front_bank), 0);
        lookup(4'd7);
        chk_rgb("edgewr", 1, 2, 3);

        // Continuous stream across a swap edge
        for (int i = 8; i < 12; i++) begin
            bus.wr_en = 1'b1; bus.wr_addr = 4'(i); bus.wr_data = {4'hA, 4'(i), 4'h0};
            tick();
        end
        bus.wr_en = 1'b0; bus.swap_req = 1'b1;
        tick();
        bus.swap_req = 1'b0;
        for (int k = 0; k < 9; k++) begin
            bus.pix_valid   = (k < 8);
            bus.index       = 4'(8 + (k % 4));
            bus.frame_start = (k == 3);
            tick();
            if (k >= 1) begin
                int j;
                j = 8 + ((k - 1) % 4);
                chk($sformatf("stream%0d.valid", k - 1), 32'(bus.out_valid), 1);
                if (k - 1 < 3) chk_rgb($sformatf("stream%0d", k - 1), j, j, j);
                else           chk_rgb($sformatf("stream%0d", k - 1), 10, j, 0);
            end
        end
        bus.frame_start = 1'b0;
        chk("stream.front", 32'(bus.front_bank), 1);

        // Writes and pixels during INIT are dropped
        Reset = 1'b1;
        tick();
        bus.wr_en = 1'b1; bus.wr_addr = 4'd5; bus.wr_data = 12'hABC;
        bus.pix_valid = 1'b1; bus.index = 4'd5;
        Reset = 1'b0;
        wait_init(n, ov_seen);
        bus.wr_en = 1'b0; bus.pix_valid = 1'b0;
        chk("init2.cycles", 32'(n), 16);
        chk("init2.ov_seen", 32'(ov_seen), 0);
        tick();
        chk("init2.lastvalid", 32'(bus.out_valid), 0);
        lookup(4'd5);
        chk_rgb("initwr.front0", 5, 5, 5);
        bus.swap_req = 1'b1; bus.frame_start = 1'b1;
        tick();
        bus.swap_req = 1'b0; bus.frame_start = 1'b0;
        lookup(4'd5);
        chk_rgb("initwr.front1", 5, 5, 5);

        // Reset while pending with a pixel in flight
        bus.swap_req = 1'b1;
        tick();
        bus.swap_req = 1'b0;
        bus.index = 4'd9; bus.pix_valid = 1'b1;
        tick();
        bus.pix_valid = 1'b0;
        Reset = 1'b1;
        tick();
        chk("rstp.pending", 32'(bus.swap_pending), 0);
        chk("rstp.front", 32'(bus.front_bank), 0);
        chk("rstp.busy", 32'(bus.busy), 1);
        chk("rstp.valid", 32'(bus.out_valid), 0);
        chk_rgb("rstp", 0, 0, 0);
        Reset = 1'b0;
        wait_init(n, ov_seen);
        chk("init3.cycles", 32'(n), 16);
        chk("init3.ov_seen", 32'(ov_seen), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/palette_lut.md
PALETTE_LUT -- requirements
Module: palette_lut

Interface
REQ-001 SHALL have parameter IDX_W, default 4: pixel colour-index width; palette depth DEPTH = 2**IDX_W.
REQ-002 SHALL have parameter CH_W, default 4: bits per colour channel; legal only when IDX_W >= CH_W.
REQ-003 SHALL have parameter TRANS_IDX, default 0: index flagged as transparent.
REQ-004 SHALL have port Clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port Reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port index, input, IDX_W: pixel colour index.
REQ-007 SHALL have port pix_valid, input, 1: index is valid this cycle.
REQ-008 SHALL have port frame_start, input, 1: one-cycle pulse at vertical-blank start.
REQ-009 SHALL have port wr_en, input, 1: palette write strobe.
REQ-010 SHALL have port wr_addr, input, IDX_W: palette entry to write.
REQ-011 SHALL have port wr_data, input, 3*CH_W: {red, green, blue}.
REQ-012 SHALL have port swap_req, input, 1: pulse requesting a bank swap at the next frame_start.
REQ-013 SHALL have ports red, green, blue, output, CH_W each: looked-up colour.
REQ-014 SHALL have port out_valid, output, 1: red/green/blue valid.
REQ-015 SHALL have port out_transparent, output, 1: pipelined index equalled TRANS_IDX.
REQ-016 SHALL have port busy, output, 1: initialisation in progress; writes ignored.
REQ-017 SHALL have port swap_pending, output, 1: swap armed, waiting for frame_start.
REQ-018 SHALL have port front_bank, output, 1: bank currently used for lookups.

Function
REQ-019 SHALL hold two DEPTH x 3*CH_W palette banks: front (read) and back (write).
REQ-020 SHALL implement FSM states INIT, RUN, PEND: INIT -> RUN when init counter = DEPTH-1; RUN -> PEND on swap_req; PEND -> RUN on frame_start, performing the swap.
REQ-021 In INIT, SHALL write entry i (i = counter, 0..DEPTH-1, one per cycle) to both banks, each channel = i[IDX_W-1 -: CH_W] (greyscale ramp); busy = 1 throughout INIT; INIT lasts exactly DEPTH cycles.
REQ-022 In RUN/PEND, wr_en SHALL write wr_data to back-bank entry wr_addr on that edge; wr_en during INIT SHALL be dropped.
REQ-023 Lookup SHALL have fixed 2-cycle latency: index/pix_valid registered (stage 1), bank read registered to outputs (stage 2); out_valid = pix_valid delayed 2 cycles, forced 0 for any stage-1 sample taken while busy.
REQ-024 out_transparent SHALL be (index == TRANS_IDX) delayed 2 cycles, aligned with red/green/blue; 0 whenever out_valid is 0.
REQ-025 When out_valid = 0, red/green/blue SHALL hold their previous values.
REQ-026 Swap SHALL toggle front_bank on the edge where frame_start is sampled in PEND; a lookup whose stage-1 sample occurs on or after that edge SHALL read the new front bank.
REQ-027 swap_req and frame_start in the same RUN cycle SHALL swap on that edge (no extra frame of delay).
REQ-028 swap_req while in PEND SHALL have no effect; frame_start in RUN without swap_req SHALL have no effect.
REQ-029 wr_en on the swap edge SHALL write the pre-swap back bank (becomes front, visible to next lookup).
REQ-030 Read and write of the same entry in the same cycle are in different banks; no hazard handling is required.
REQ-031 swap_pending SHALL be 1 exactly while in PEND.

Reset
REQ-032 Reset SHALL, on the next edge, enter INIT with counter 0, front_bank = 0, swap_pending = 0, busy = 1, out_valid = 0, out_transparent = 0, red/green/blue = 0, pipeline valid bits cleared.
REQ-033 Reset asserted mid-INIT, mid-PEND or mid-lookup SHALL abandon the operation and restart INIT; pending swap and in-flight pixels are discarded.

Verification
REQ-034 Reset, then sample busy: busy = 1 for exactly 16 cycles (defaults); then index=9, pix_valid=1 -> 2 cycles later out_valid=1, rgb = 9/9/9.
REQ-035 After init, wr_en addr 3 data 0xD95; lookup index 3 -> rgb still 3/3/3; swap_req, then frame_start -> front_bank=1, lookup index 3 -> D/9/5.
REQ-036 swap_req and frame_start same cycle -> swap_pending never 1, front_bank toggles that edge; second swap_req in PEND -> single toggle only.
REQ-037 Index 0 (TRANS_IDX) with pix_valid -> out_transparent=1 aligned with out_valid; pix_valid=0 -> out_valid=0, out_transparent=0, rgb held.
REQ-038 Write entry 5 during INIT -> ignored (entry stays 5/5/5 after swap); Reset asserted in PEND -> swap_pending=0, front_bank=0, INIT restarts.
REQ-039 Continuous pix_valid with incrementing index across a swap edge -> every output valid, no gap, colour source changes exactly at the first stage-1 sample on/after the swap edge.
